// File: rtl/sram_bus_sequencer.sv
// Sequences single memory requests into timed asynchronous SRAM byte cycles.
// Optional SRAM_WORD16_EN: 16-bit requests run as two byte cycles (addr, then addr+1).
module sram_bus_sequencer #(
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 2
) (
    input  logic        clk_chipset,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [20:0] addr,
`ifdef SRAM_WORD16_EN
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
`else
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
`endif
    output logic        ack,
    output logic        busy,
    output logic [20:0] sram_addr,
    output logic [7:0]  sram_dout,
    output logic        sram_oe,
    input  logic [7:0]  sram_din,
    output logic        sram_we_n
);

    localparam logic [3:0] RD_LAST = 4'(RD_WAIT - 1);
    localparam logic [3:0] WR_LAST = 4'(WR_WAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_WAIT,
        S_WR_SETUP,
        S_WR_PULSE,
        S_WR_HOLD,
        S_DONE
`ifdef SRAM_WORD16_EN
        , S_NEXT
`endif
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    state_t      w_after_byte;
    logic [3:0]  r_cnt;
    logic [20:0] r_addr;
    logic [7:0]  r_dout;
    logic        r_oe;
    logic        r_we_n;
    logic        r_ack;
    logic        r_busy;
    logic [7:0]  w_rbyte;
`ifdef SRAM_WORD16_EN
    logic [15:0] r_rdata;
    logic        r_we;
    logic        r_hi;
    logic [7:0]  r_wdata_hi;
`else
    logic [7:0]  r_rdata;
`endif

    // Out-of-range bytes (addr[20]=1) read back as all ones.
    assign w_rbyte = r_addr[20] ? 8'hFF : sram_din;

    always_ff @(posedge clk_chipset or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_after_byte = S_DONE;
`ifdef SRAM_WORD16_EN
        w_after_byte = r_hi ? S_DONE : S_NEXT;
`endif
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_next_state = we ? S_WR_SETUP : S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (r_cnt == RD_LAST) begin
                    w_next_state = w_after_byte;
                end
            end
            S_WR_SETUP: w_next_state = S_WR_PULSE;
            S_WR_PULSE: begin
                if (r_cnt == WR_LAST) begin
                    w_next_state = S_WR_HOLD;
                end
            end
            S_WR_HOLD:  w_next_state = w_after_byte;
            S_DONE:     w_next_state = S_IDLE;
`ifdef SRAM_WORD16_EN
            S_NEXT:     w_next_state = r_we ? S_WR_SETUP : S_RD_WAIT;
`endif
            default:    w_next_state = S_IDLE;
        endcase
    end

    // Strobes are registered from the next state so pins never see input glitches.
    always_ff @(posedge clk_chipset or posedge reset) begin
        if (reset) begin
            r_cnt      <= 4'd0;
            r_addr     <= 21'd0;
            r_dout     <= 8'd0;
            r_oe       <= 1'b0;
            r_we_n     <= 1'b1;
            r_ack      <= 1'b0;
            r_busy     <= 1'b0;
`ifdef SRAM_WORD16_EN
            r_rdata    <= 16'd0;
            r_we       <= 1'b0;
            r_hi       <= 1'b0;
            r_wdata_hi <= 8'd0;
`else
            r_rdata    <= 8'd0;
`endif
        end else begin
            r_busy <= (w_next_state != S_IDLE);
            r_ack  <= (w_next_state == S_DONE);
            r_oe   <= (w_next_state == S_WR_SETUP) || (w_next_state == S_WR_PULSE) ||
                      (w_next_state == S_WR_HOLD);
            r_we_n <= !((w_next_state == S_WR_PULSE) && !r_addr[20]);

            if (((r_state == S_RD_WAIT) || (r_state == S_WR_PULSE)) && (w_next_state == r_state)) begin
                r_cnt <= r_cnt + 4'd1;
            end else begin
                r_cnt <= 4'd0;
            end

            if ((r_state == S_IDLE) && req) begin
                r_addr <= addr;
                r_dout <= wdata[7:0];
`ifdef SRAM_WORD16_EN
                r_we       <= we;
                r_hi       <= 1'b0;
                r_wdata_hi <= wdata[15:8];
`endif
            end

            if ((r_state == S_RD_WAIT) && (w_next_state != S_RD_WAIT)) begin
`ifdef SRAM_WORD16_EN
                if (r_hi) begin
                    r_rdata[15:8] <= w_rbyte;
                end else begin
                    r_rdata[7:0] <= w_rbyte;
                end
`else
                r_rdata <= w_rbyte;
`endif
            end

`ifdef SRAM_WORD16_EN
            if (r_state == S_NEXT) begin
                r_addr <= r_addr + 21'd1;
                r_dout <= r_wdata_hi;
                r_hi   <= 1'b1;
            end
`endif
        end
    end

    assign sram_addr = r_addr;
    assign sram_dout = r_dout;
    assign sram_oe   = r_oe;
    assign sram_we_n = r_we_n;
    assign rdata     = r_rdata;
    assign ack       = r_ack;
    assign busy      = r_busy;

endmodule
